// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory load path: loader FSM states,
// word geometry and the HALT encoding also used by the decoder and debug unit.
package program_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } loader_state_e;

  localparam int NBITS_DEF      = 8;
  localparam int INST_BITS_DEF  = 32;
  localparam int BYTES_PER_WORD = INST_BITS_DEF / NBITS_DEF;

  localparam logic [INST_BITS_DEF-1:0] HALT_INST_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// Big-endian byte-to-word shift register with a byte counter; word_ready_o
// flags the cycle whose accepted byte completes a word (word_next_o is then valid).
module program_loader_byte_word_packer #(
  parameter int NBITS     = 8,
  parameter int INST_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 clr_i,
  input  logic                 shift_i,
  input  logic [NBITS-1:0]     byte_i,
  output logic [INST_BITS-1:0] word_next_o,
  output logic                 word_ready_o
);

  localparam int BPW = INST_BITS / NBITS;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BPW - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [INST_BITS-1:0] word_q;

  assign word_next_o  = {word_q[INST_BITS-NBITS-1:0], byte_i};
  assign word_ready_o = shift_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Data path: cleared on a new load only; a completed word is consumed via word_next_o.
  always_ff @(posedge i_clk) begin
    if (clr_i) begin
      word_q <= '0;
    end else if (shift_i) begin
      word_q <= word_next_o;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Instruction-memory loader: packs UART bytes into big-endian words and writes
// them at consecutive word addresses until a HALT word or the memory fills.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int INST_BITS = INST_BITS_DEF,
  parameter int CELLS     = 256,
  parameter logic [INST_BITS-1:0] HALT_INST = INST_BITS'(HALT_INST_DEF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NBITS-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  output logic [INST_BITS-1:0] o_addr_wr,
  output logic [INST_BITS-1:0] o_data,
  output logic                 o_wr_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_full,
  output logic [INST_BITS-1:0] o_inst_count
);

  localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - BYTES_PER_WORD);
  localparam logic [INST_BITS-1:0] WORD_STEP = INST_BITS'(BYTES_PER_WORD);

  loader_state_e        state_q, state_d;
  logic [INST_BITS-1:0] addr_q, addr_d;
  logic [INST_BITS-1:0] data_q, data_d;
  logic [INST_BITS-1:0] cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 full_q, full_d;

  logic                 pk_clr, pk_shift, pk_ready;
  logic [INST_BITS-1:0] pk_word_next;

  program_loader_byte_word_packer #(
    .NBITS     (NBITS),
    .INST_BITS (INST_BITS)
  ) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .clr_i        (pk_clr),
    .shift_i      (pk_shift),
    .byte_i       (i_rx_data),
    .word_next_o  (pk_word_next),
    .word_ready_o (pk_ready)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    full_d   = full_q;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_RECV;
          addr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          full_d  = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      S_RECV: begin
        pk_shift = i_rx_valid;
        if (pk_ready) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
          data_d  = pk_word_next;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (data_q == HALT_INST || addr_q == LAST_ADDR) begin
          // Terminal write: any byte arriving now belongs to no load and is dropped.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          full_d  = (data_q != HALT_INST);
        end else begin
          // Continuing: a byte in this cycle becomes byte 0 of the next word.
          state_d  = S_RECV;
          addr_d   = addr_q + WORD_STEP;
          pk_shift = i_rx_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  assign o_addr_wr    = addr_q;
  assign o_data       = data_q;
  assign o_wr_en      = wr_en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_full       = full_q;
  assign o_inst_count = cnt_q;

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction memory's load port. Receives a byte stream from the UART receiver, packs each four bytes into one big-endian 32-bit instruction, and issues single-cycle writes at consecutive word addresses into instruction memory. Loading ends on a HALT instruction or when memory is full. Sits between the UART RX block and the instruction memory write port, under control of the debug unit.

## Interface
- NBITS, 8, width of one received byte and one memory cell
- INST_BITS, 32, instruction and address width
- CELLS, 256, byte cells in instruction memory; capacity is CELLS/4 words
- HALT_INST, 32'hFFFF_FFFF, encoding that terminates loading
- i_clk  in  1  clock; all state updates on posedge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse from the debug unit: begin a new load
- i_rx_data  in  NBITS  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
- o_addr_wr  out  INST_BITS  byte address of the word being written (multiple of 4)
- o_data  out  INST_BITS  packed instruction
- o_wr_en  out  1  write strobe to instruction memory, one cycle per word
- o_busy  out  1  high while in RECV or WRITE
- o_done  out  1  load finished; held until the next i_start or reset
- o_full  out  1  load ended because memory filled, not because of HALT
- o_inst_count  out  INST_BITS  words written in the current/last load, HALT included

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: bytes ignored. i_start -> RECV; clear address, byte counter, word register, o_inst_count, o_done, o_full.
- RECV: on i_rx_valid, word <= {word[INST_BITS-NBITS-1:0], i_rx_data}; byte_cnt++. First byte received lands in bits [31:24] (big-endian: byte 0 goes to addr+0). On the 4th byte -> WRITE, byte_cnt <= 0.
- WRITE (exactly one cycle): o_wr_en=1, o_addr_wr=current address, o_data=packed word; o_inst_count++.
  - word == HALT_INST -> DONE, o_full=0.
  - else address == CELLS-4 -> DONE, o_full=1.
  - else address += 4 -> RECV.
  - i_rx_valid during WRITE on the RECV path: byte captured as byte 0 of the next word (byte_cnt=1); never dropped. On the DONE path it is discarded.
- DONE: o_done=1, o_busy=0, bytes ignored. i_start -> same as IDLE start (restart from address 0).
- i_start while busy: ignored.
- Reset mid-load: return to IDLE immediately; partially packed word discarded; no write issued.

## Timing
- All outputs registered. Reset values: o_addr_wr=0, o_data=0, o_wr_en=0, o_busy=0, o_done=0, o_full=0, o_inst_count=0; state IDLE.
- o_wr_en asserts in the cycle after the posedge sampling the 4th i_rx_valid; high for one cycle. o_addr_wr/o_data stable that whole cycle, so the memory's negedge write captures them.
- o_done and o_full rise in the cycle after the WRITE cycle; o_busy falls at the same edge.
- o_inst_count increments at the edge that ends WRITE.
- Minimum sustained throughput: one byte per cycle with no loss.
- Address arithmetic in INST_BITS bits; full check is an equality against CELLS-4, so no wrap can occur.

## Structure
- Shared package: state encoding, BYTES_PER_WORD = INST_BITS/NBITS (4), default HALT_INST constant (shared with the decoder and debug unit).
- One sub-module is natural: byte_word_packer (shift register plus 2-bit byte counter, word-ready pulse). FSM, address counter and instruction counter stay in program_loader.

## Test plan
- Reset then idle: bytes 0x12,0x34 with no i_start -> no o_wr_en, all outputs 0.
- i_start; bytes 20 01 00 05, 00 00 00 00, FF FF FF FF -> writes 0x20010005@0, 0x00000000@4, 0xFFFFFFFF@8; o_done=1, o_full=0, o_inst_count=3.
- Back-to-back bytes every cycle across word boundaries, incl. a byte in the WRITE cycle -> every word correct, no byte lost.
- 64 non-HALT words (CELLS=256) -> last write at 0xFC, o_done=1, o_full=1, o_inst_count=64; 65th word's bytes ignored.
- Reset after 2 bytes of word 1 -> no write; new i_start then 4 bytes -> write at address 0.
- i_start in DONE -> counters cleared, next word written at address 0; i_start during RECV ignored.
